// File: rtl/tv80_bus_target_pkg.sv
// tv80_bus_target_pkg
// Shared encodings for the tv80 bus target:
//   - state_e     : responder FSM states (IDLE/WAIT/ACT/HOLD)
//   - acc_class_e : decoded bus access classes
//   - BUS_IDLE    : value driven on di when nothing is being served
//   - STATUS_PEND_BIT, PORT_* : I/O window layout (ports +0..+3)
package tv80_bus_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACT,
    ST_HOLD
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_RD_MEM,
    CLS_WR_MEM,
    CLS_RD_IO,
    CLS_WR_IO,
    CLS_INTA
  } acc_class_e;

  localparam logic [7:0] BUS_IDLE        = 8'hFF;
  localparam int         STATUS_PEND_BIT = 0;

  localparam logic [1:0] PORT_P0     = 2'd0;
  localparam logic [1:0] PORT_P1     = 2'd1;
  localparam logic [1:0] PORT_P2     = 2'd2;
  localparam logic [1:0] PORT_STATUS = 2'd3;

  function automatic logic cls_is_mem(input acc_class_e c);
    return (c == CLS_RD_MEM) || (c == CLS_WR_MEM);
  endfunction

endpackage

// File: rtl/tv80_tgt_wait_gen.sv
// tv80_tgt_wait_gen
// Wait-state generator: a 4-bit down-counter plus the combinational
// first-cycle wait request, so a stall of N cycles starts in the very cycle
// the access is detected.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        access detected this cycle (responder idle)
//   count [3:0]  wait cycles N requested for this access
//   wait_n       active-low wait request, low for exactly N cycles
//   done         counting finished; the access may proceed to its action cycle
module tv80_tgt_wait_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] count,
  output logic       wait_n,
  output logic       done
);

  logic [3:0] r_cnt;
  logic       r_busy;
  logic       w_load;

  assign w_load = start && (count != 4'd0);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 4'd0;
      r_busy <= 1'b0;
    end else if (w_load) begin
      r_cnt  <= count - 4'd1;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == 4'd0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // The detection cycle counts as the first stall cycle, so the request is
  // released in the last counting cycle (count 0): total stall is exactly N.
  assign wait_n = !(w_load || (r_busy && (r_cnt != 4'd0)));
  assign done   = r_busy && (r_cnt == 4'd0);

endmodule

// File: rtl/tv80_bus_target.sv
// tv80_bus_target
// Synchronous Z80-bus responder for the tv80 CPU: serves a RAM window and a
// 4-port I/O window, stretches accesses with wait_n and answers interrupt
// acknowledge cycles.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   m1_n mreq_n iorq_n rd_n wr_n rfsh_n   CPU strobes (active low)
//   A [15:0], cpu_do [7:0]          CPU address and write data
//   di [7:0]                        read data to CPU (combinational)
//   wait_n, int_n                   wait request / maskable interrupt (active low)
//   irq_req, irq_vec [7:0]          interrupt source (rising edge), IM2 vector
//   io_regs [23:0]                  {p2,p1,p0} I/O register contents
// Build option: define TV80_BUS_TARGET_IM2_EN to return irq_vec on INTA;
// otherwise INTA reads 8'hFF (RST 38h) and irq_vec is ignored.
module tv80_bus_target
  import tv80_bus_target_pkg::*;
#(
  parameter int          MEM_AW   = 10,
  parameter logic [15:0] MEM_BASE = 16'h8000,
  parameter logic [7:0]  IO_BASE  = 8'h10,
  parameter int          MEM_WAIT = 1,
  parameter int          IO_WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic        int_n,
  input  logic        irq_req,
  input  logic [7:0]  irq_vec,
  output logic [23:0] io_regs
);

  localparam logic [3:0] MEM_N = 4'(MEM_WAIT);
  localparam logic [3:0] IO_N  = 4'(IO_WAIT);

  state_e          r_state, w_state_nxt;
  acc_class_e      r_class, w_class_nxt;
  acc_class_e      w_det_class, w_cur_class;
  logic            r_armed;
  logic [2:0][7:0] r_io;
  logic            r_pending, r_irq_d;
  logic [7:0]      r_mem [2**MEM_AW];

  logic       w_mem_hit, w_io_hit, w_bus_idle;
  logic       w_start, w_done, w_wait_n;
  logic [3:0] w_count;
  logic       w_act_wr_io, w_pend_clr, w_irq_rise;
  logic [7:0] w_status, w_port_rd, w_vec, w_rdata;

  assign w_mem_hit  = (A[15:MEM_AW] == MEM_BASE[15:MEM_AW]);
  assign w_io_hit   = (A[7:2] == IO_BASE[7:2]);
  assign w_bus_idle = rd_n && wr_n && iorq_n && mreq_n;

  // r_armed stays low after reset until the bus has gone idle once, so a
  // strobe that was live across a reset is never served a second time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed <= 1'b0;
    end else if (w_bus_idle) begin
      r_armed <= 1'b1;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_det_class = CLS_NONE;
    if (r_armed) begin
      if (!m1_n && !iorq_n)                               w_det_class = CLS_INTA;
      else if (!mreq_n && rfsh_n && !rd_n && w_mem_hit)   w_det_class = CLS_RD_MEM;
      else if (!mreq_n && !wr_n && w_mem_hit)             w_det_class = CLS_WR_MEM;
      else if (!iorq_n && m1_n && !rd_n && w_io_hit)      w_det_class = CLS_RD_IO;
      else if (!iorq_n && m1_n && !wr_n && w_io_hit)      w_det_class = CLS_WR_IO;
    end
  end

  assign w_start = (r_state == ST_IDLE) && (w_det_class != CLS_NONE);
  assign w_count = cls_is_mem(w_det_class) ? MEM_N : IO_N;

  tv80_tgt_wait_gen u_wait_gen (
    .clk    (clk),
    .rst_n  (reset_n),
    .start  (w_start),
    .count  (w_count),
    .wait_n (w_wait_n),
    .done   (w_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_class_nxt = r_class;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_class_nxt = w_det_class;
          w_state_nxt = (w_count == 4'd0) ? ST_ACT : ST_WAIT;
        end
      end
      ST_WAIT: if (w_done) w_state_nxt = ST_ACT;
      ST_ACT:  w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_bus_idle) begin
          w_state_nxt = ST_IDLE;
          w_class_nxt = CLS_NONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_class <= CLS_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_class <= w_class_nxt;
    end
  end

  // Writes: address and data are taken live in the action cycle.
  assign w_act_wr_io = (r_state == ST_ACT) && (r_class == CLS_WR_IO);
  assign w_pend_clr  = ((r_state == ST_ACT) && (r_class == CLS_INTA)) ||
                       (w_act_wr_io && (A[1:0] == PORT_STATUS) && cpu_do[STATUS_PEND_BIT]);
  assign w_irq_rise  = irq_req && !r_irq_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_io <= '0;
    end else if (w_act_wr_io) begin
      case (A[1:0])
        PORT_P0: r_io[0] <= cpu_do;
        PORT_P1: r_io[1] <= cpu_do;
        PORT_P2: r_io[2] <= cpu_do;
        default: ;
      endcase
    end
  end

  // A new edge in the same cycle as a clear keeps the interrupt pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_d   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_irq_d <= irq_req;
      if (w_irq_rise)      r_pending <= 1'b1;
      else if (w_pend_clr) r_pending <= 1'b0;
    end
  end

  // NOTE: the RAM array has no reset; its contents are undefined after
  // power-up and only the written bytes are meaningful.
  always_ff @(posedge clk) begin
    if ((r_state == ST_ACT) && (r_class == CLS_WR_MEM)) begin
      r_mem[A[MEM_AW-1:0]] <= cpu_do;
    end
  end

  always_comb begin
    w_status                  = '0;
    w_status[STATUS_PEND_BIT] = r_pending;
  end

  always_comb begin
    case (A[1:0])
      PORT_P0: w_port_rd = r_io[0];
      PORT_P1: w_port_rd = r_io[1];
      PORT_P2: w_port_rd = r_io[2];
      default: w_port_rd = w_status;
    endcase
  end

`ifdef TV80_BUS_TARGET_IM2_EN
  assign w_vec = irq_vec;
`else
  // irq_vec is masked off but kept referenced so the port is not dangling.
  assign w_vec = BUS_IDLE | (irq_vec & 8'h00);
`endif

  // Data is served only while the class's own strobes are still asserted.
  assign w_cur_class = (r_state == ST_IDLE) ? w_det_class : r_class;

  always_comb begin
    w_rdata = BUS_IDLE;
    case (w_cur_class)
      CLS_RD_MEM: if (!mreq_n && !rd_n) w_rdata = r_mem[A[MEM_AW-1:0]];
      CLS_RD_IO:  if (!iorq_n && !rd_n) w_rdata = w_port_rd;
      CLS_INTA:   if (!m1_n && !iorq_n) w_rdata = w_vec;
      default:    ;
    endcase
  end

  assign di      = w_wait_n ? w_rdata : BUS_IDLE;
  assign wait_n  = w_wait_n;
  assign int_n   = !r_pending;
  assign io_regs = r_io;

endmodule
